// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM-style pipeline control logic: register index width
// and the per-stage shadow record kept for hazard detection.
package arm_pipe_pkg;

    localparam int REG_W = 4;

    typedef struct packed {
        logic             wb;
        logic             mem_read;
        logic [REG_W-1:0] dest;
    } stage_shadow_t;

    localparam stage_shadow_t SHADOW_NOP = '0;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational matcher: reports whether a tracked producer writes either of
// the two ID source registers.
module hazard_cmp
    import arm_pipe_pkg::*;
(
    input  logic             i_wb,
    input  logic [REG_W-1:0] i_dest,
    input  logic [REG_W-1:0] i_src1,
    input  logic [REG_W-1:0] i_src2,
    output logic             o_hit1,
    output logic             o_hit2
);

    // R0 is an ordinary register, so index 0 matches like any other.
    assign o_hit1 = i_wb && (i_dest == i_src1);
    assign o_hit2 = i_wb && (i_dest == i_src2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks EXE/MEM producers, raises stall/bubble on RAW
// dependencies, flushes on taken branches, freezes on memory wait.
module hazard_ctrl #(
    parameter int REG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             mem_stall,
    input  logic             branch_taken,
    input  logic             id_valid,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [REG_W-1:0] id_dest,
    output logic             hazard,
    output logic             bubble,
    output logic             flush,
    output logic             freeze_all,
    output logic [CNT_W-1:0] stall_count
);

    import arm_pipe_pkg::*;

    stage_shadow_t    r_shadow_p0;
    logic             r_mem_wb_p1;
    logic [REG_W-1:0] r_mem_dest_p1;
    logic [CNT_W-1:0] r_stall_cnt;

    stage_shadow_t    w_exe_next;
    logic             w_e_hit1;
    logic             w_e_hit2;
    logic             w_m_hit1;
    logic             w_m_hit2;
    logic             w_raw;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_cmp u_cmp_exe (
        .i_wb   (r_shadow_p0.wb),
        .i_dest (r_shadow_p0.dest),
        .i_src1 (id_src1),
        .i_src2 (id_src2),
        .o_hit1 (w_e_hit1),
        .o_hit2 (w_e_hit2)
    );

    hazard_cmp u_cmp_mem (
        .i_wb   (r_mem_wb_p1),
        .i_dest (r_mem_dest_p1),
        .i_src1 (id_src1),
        .i_src2 (id_src2),
        .o_hit1 (w_m_hit1),
        .o_hit2 (w_m_hit2)
    );

    always_comb begin
        w_raw      = 1'b0;
        hazard     = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        freeze_all = mem_stall;
        w_exe_next = SHADOW_NOP;

        // With forwarding only a load in EXE cannot supply its value in time.
        if (fwd_en) begin
            w_raw = id_valid && r_shadow_p0.mem_read &&
                    (w_e_hit1 || (id_two_src && w_e_hit2));
        end else begin
            w_raw = id_valid &&
                    (w_e_hit1 || w_m_hit1 ||
                     (id_two_src && (w_e_hit2 || w_m_hit2)));
        end

        // A pending memory wait masks the branch; EXE re-raises it afterwards.
        if (!mem_stall) begin
            if (branch_taken) begin
                flush = 1'b1;
            end else begin
                hazard = w_raw;
                bubble = w_raw;
            end
        end

        if (!(flush || bubble)) begin
            w_exe_next.wb       = id_wb_en;
            w_exe_next.mem_read = id_mem_read;
            w_exe_next.dest     = id_dest;
        end
    end

    // EXE (p0) -> MEM (p1) shadow advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_p0   <= SHADOW_NOP;
            r_mem_wb_p1   <= 1'b0;
            r_mem_dest_p1 <= '0;
            r_stall_cnt   <= '0;
        end else if (!mem_stall) begin
            r_shadow_p0   <= w_exe_next;
            r_mem_wb_p1   <= r_shadow_p0.wb;
            r_mem_dest_p1 <= r_shadow_p0.dest;
            if (hazard) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// randomized traffic compared against an instruction-level reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, fwd_en, mem_stall, branch_taken;
    logic       id_valid, id_two_src, id_wb_en, id_mem_read;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       hazard, bubble, flush, freeze_all;
    logic [31:0] stall_count;
    logic       hazard4, bubble4, flush4, freeze4;
    logic [3:0] stall_count4;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the two in-flight instructions ahead of ID.
    // slot 0 = one instruction ahead (EXE), slot 1 = two ahead (MEM).
    bit         pipe_wb   [2];
    bit         pipe_ld   [2];
    int         pipe_dest [2];
    longint     m_cnt;
    int         m_cnt4;
    bit         exp_h, exp_f, exp_z;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .id_valid(id_valid), .id_two_src(id_two_src),
        .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .id_dest(id_dest),
        .hazard(hazard), .bubble(bubble), .flush(flush),
        .freeze_all(freeze_all), .stall_count(stall_count)
    );

    hazard_ctrl #(.REG_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .id_valid(id_valid), .id_two_src(id_two_src),
        .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .id_dest(id_dest),
        .hazard(hazard4), .bubble(bubble4), .flush(flush4),
        .freeze_all(freeze4), .stall_count(stall_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit writes(input int slot, input logic [3:0] r);
        return pipe_wb[slot] && (pipe_dest[slot] == int'(r));
    endfunction

    task automatic model_eval();
        bit dep;
        if (fwd_en)
            dep = pipe_ld[0] && (writes(0, id_src1) || (id_two_src && writes(0, id_src2)));
        else
            dep = writes(0, id_src1) || writes(1, id_src1) ||
                  (id_two_src && (writes(0, id_src2) || writes(1, id_src2)));
        dep   = dep && id_valid;
        exp_z = mem_stall;
        exp_f = !mem_stall && branch_taken;
        exp_h = !mem_stall && !branch_taken && dep;
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("hazard", hazard, exp_h);
        chk("bubble", bubble, exp_h);
        chk("flush", flush, exp_f);
        chk("freeze_all", freeze_all, exp_z);
        chk("stall_count", stall_count, m_cnt[31:0]);
        chk("hazard_w4", hazard4, exp_h);
        chk("stall_count_w4", stall_count4, m_cnt4);
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pipe_wb[i] = 0; pipe_ld[i] = 0; pipe_dest[i] = 0;
            end
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (!mem_stall) begin
            pipe_wb[1]   = pipe_wb[0];
            pipe_ld[1]   = 1'b0;
            pipe_dest[1] = pipe_dest[0];
            if (exp_f || exp_h) begin
                pipe_wb[0] = 0; pipe_ld[0] = 0; pipe_dest[0] = 0;
            end else begin
                pipe_wb[0] = id_wb_en; pipe_ld[0] = id_mem_read; pipe_dest[0] = id_dest;
            end
            if (exp_h) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        @(negedge clk);
    endtask

    task automatic id_set(input bit v, input bit two, input int s1, input int s2,
                          input bit wb, input bit ld, input int d);
        id_valid = v; id_two_src = two; id_src1 = 4'(s1); id_src2 = 4'(s2);
        id_wb_en = wb; id_mem_read = ld; id_dest = 4'(d);
    endtask

    task automatic do_reset(input bit fwd);
        rst = 1'b1; mem_stall = 1'b0; branch_taken = 1'b0; fwd_en = fwd;
        id_set(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset(1'b0);
        settle();
        chk("reset_hazard", hazard, 0);
        chk("reset_count", stall_count, 0);

        // ALU producer, no forwarding: two stall cycles
        id_set(1, 0, 5, 0, 1, 0, 1); settle(); chk("nofwd_add", hazard, 0); tick();
        id_set(1, 0, 1, 0, 1, 0, 3);
        settle(); chk("nofwd_stall1", hazard, 1); tick();
        settle(); chk("nofwd_stall2", bubble, 1); tick();
        settle(); chk("nofwd_release", hazard, 0); chk("nofwd_count", stall_count, 2); tick();

        // Load-use with forwarding: exactly one stall
        do_reset(1'b1);
        id_set(1, 0, 4, 0, 1, 1, 2); settle(); tick();
        id_set(1, 1, 6, 2, 1, 0, 7);
        settle(); chk("ldu_stall", hazard, 1); tick();
        settle(); chk("ldu_release", hazard, 0); chk("ldu_count", stall_count, 1); tick();

        // ALU producer with forwarding: no stall
        do_reset(1'b1);
        id_set(1, 0, 4, 0, 1, 0, 2); settle(); tick();
        id_set(1, 1, 6, 2, 1, 0, 7); settle(); chk("fwd_alu", hazard, 0); tick();

        // Taken branch against a dependent instruction
        do_reset(1'b1);
        id_set(1, 0, 4, 0, 1, 1, 2); settle(); tick();
        id_set(1, 1, 2, 9, 1, 0, 7); branch_taken = 1'b1;
        settle(); chk("br_flush", flush, 1); chk("br_hazard", hazard, 0); chk("br_bubble", bubble, 0);
        tick();
        branch_taken = 1'b0;
        settle(); chk("br_after", hazard, 0); chk("br_exe_shadow", 32'(dut.r_shadow_p0), 0);
        tick();

        // Memory wait during a load-use hazard
        do_reset(1'b1);
        id_set(1, 0, 4, 0, 1, 1, 2); settle(); tick();
        id_set(1, 1, 6, 2, 1, 0, 7); mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("ms_freeze", freeze_all, 1); chk("ms_hazard", hazard, 0);
            chk("ms_count", stall_count, 0); tick();
        end
        mem_stall = 1'b0;
        settle(); chk("ms_after_stall", hazard, 1); tick();
        settle(); chk("ms_after_release", hazard, 0); chk("ms_after_count", stall_count, 1); tick();

        // Operand-gating: unused src2, and no source read at all
        do_reset(1'b1);
        id_set(1, 0, 4, 0, 1, 1, 3); settle(); tick();
        id_set(1, 0, 5, 3, 1, 0, 6); settle(); chk("one_src", hazard, 0);
        id_set(0, 0, 3, 0, 1, 0, 6); settle(); chk("no_src", hazard, 0);
        id_set(1, 1, 5, 3, 1, 0, 6); settle(); chk("two_src", hazard, 1);
        tick();

        // Saturation on the narrow counter, then reset during a stall
        do_reset(1'b0);
        id_set(1, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 40; i++) begin settle(); tick(); end
        settle();
        chk("sat_cnt4", stall_count4, 15);
        chk("sat_cnt32", stall_count, 26);
        chk("sat_in_stall", hazard, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        settle();
        chk("rst_hazard", hazard, 0); chk("rst_count", stall_count, 0); chk("rst_count4", stall_count4, 0);
        tick();

        // Randomized traffic with small register indices to provoke matches
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            mem_stall    = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) fwd_en = ~fwd_en;
            id_set($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3));
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the freeze and flush inputs of the IF/ID and ID/EX stage registers.
- Keeps shadow copies of the destination, write-back and load flags for the instructions in EXE and MEM.
- Compares them against the source registers of the instruction in ID and decides whether to stall, insert a bubble or flush.
- Also handles taken-branch flush, global memory-wait freeze and a saturating stall-cycle counter.

Parameters:
- REG_W, 4, register-index width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- fwd_en  in  1  1 = forwarding unit present (stall only on load-use); 0 = stall until producer retires
- mem_stall  in  1  data-memory wait; whole pipeline holds
- branch_taken  in  1  EXE-stage taken branch (B and condition true)
- id_valid  in  1  ID instruction reads src1 (0 for B, NOP)
- id_two_src  in  1  ID instruction also reads src2 (register operand or STR)
- id_src1, id_src2  in  REG_W  ID source indices
- id_wb_en, id_mem_read  in  1  ID instruction control bits
- id_dest  in  REG_W  ID destination index
- hazard  out  1  hold PC and IF/ID
- bubble  out  1  load zeros into ID/EX this cycle
- flush  out  1  clear IF/ID and ID/EX
- freeze_all  out  1  hold every stage register (equals mem_stall)
- stall_count  out  CNT_W  cycles with hazard=1, saturating

Behaviour:
- Internal state: EXE shadow {wb, mem_read, dest} and MEM shadow {wb, dest}.
- Reset: both shadows cleared to 0 and stall_count=0. Outputs then follow the combinational rules below (hazard=bubble=flush=0 while branch_taken=mem_stall=0).
- Reset mid-run clears the shadows on that edge. The next ID instruction sees no hazard.
- Match rule: match_X(s) = X.wb && X.dest==s.
- Forwarding off (fwd_en=0): raw = id_valid && (match_E(src1) || match_M(src1) || id_two_src && (match_E(src2) || match_M(src2))).
- Forwarding on (fwd_en=1): raw = id_valid && E.mem_read && (match_E(src1) || id_two_src && match_E(src2)).
- Priority, highest first:
  1. mem_stall=1: freeze_all=1, hazard=bubble=flush=0, shadows and counter hold, branch_taken ignored (EXE reasserts it after the stall).
  2. branch_taken=1: flush=1, hazard=bubble=0.
  3. Otherwise hazard=bubble=raw.
- Shadow update each clock when mem_stall=0:
  - MEM <= EXE {wb, dest}.
  - EXE <= 0 if (flush || bubble), else {id_wb_en, id_mem_read, id_dest}.
- WB stage is not tracked. The register file provides write-before-read in the same cycle.
- stall_count increments on each clock with hazard=1 and saturates at all-ones.
- Combinational latency: all outputs are functions of current inputs and shadows. There is no output register.
- Stall length with fwd_en=0:
  - Producer in EXE: 2 stall cycles.
  - Producer in MEM: 1 stall cycle.
- Stall length with fwd_en=1: load-use gives exactly 1 stall cycle. ALU results never stall.
- Register index 0 is ordinary (ARM R0), not hard-wired.
- Toggling fwd_en mid-run takes effect in the same cycle.

Decomposition:
- Package arm_pipe_pkg holds:
  - REG_W;
  - a stage_shadow_t struct {wb, mem_read, dest};
  - the zero constant SHADOW_NOP.
- One sub-module, hazard_cmp: combinational src-vs-shadow matcher, instantiated for the EXE and MEM shadows.

Test Plan:
- fwd_en=0: ADD R1 (wb=1, dest=1), then SUB with src1=1 → hazard=bubble=1 for 2 cycles, then 0; stall_count=2.
- fwd_en=1: LDR R2 (mem_read=1, dest=2), then ADD with src2=2, two_src=1 → hazard=1 for exactly 1 cycle. The same sequence with ADD R2 as producer → no stall.
- Dependent instruction in ID and branch_taken=1 in the same cycle → flush=1, hazard=bubble=0. Next cycle EXE shadow=0 and hazard=0.
- mem_stall=1 for 3 cycles during a load-use hazard → freeze_all=1, hazard=0, counter unchanged. After release → the 1-cycle hazard still occurs.
- id_two_src=0 with src2 matching EXE dest → no hazard. id_valid=0 with src1 matching → no hazard.
- Force stall_count to all-ones via a CNT_W=4 instance, 20 stall cycles → holds 15. Assert rst during a stall → next cycle hazard=0 and stall_count=0.
